// File: rtl/pwm_spi_host_if.sv
// Request/response port of pwm_spi_host.
// master = on-chip requester, slave = the SPI host.
interface pwm_spi_host_if #(
    parameter int unsigned DATA_BYTES = 4
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [6:0]              req_addr;
    logic [8*DATA_BYTES-1:0] req_wdata;
    logic                    rsp_valid;
    logic [8*DATA_BYTES-1:0] rsp_rdata;
    logic                    rsp_err;
    logic                    busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/pwm_spi_host.sv
// SPI mode-0 initiator that runs one framed register transaction per request.
// Optional write readback/compare is enabled by defining PWM_SPI_HOST_VERIFY_EN.
module pwm_spi_host #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned CS_SETUP   = 2,
    parameter int unsigned DATA_BYTES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    pwm_spi_host_if.slave bus,
    output logic          spi_sclk,
    output logic          spi_mosi,
    input  logic          spi_miso,
    output logic          spi_cs_n
);
    localparam int unsigned DATA_W     = 8 * DATA_BYTES;
    localparam int unsigned FRAME_BITS = 8 * (1 + DATA_BYTES);
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_DONE
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [BIT_W-1:0]      r_bit;
    logic [FRAME_BITS-1:0] r_tx;
    logic [DATA_W-1:0]     r_rx;
    logic                  r_sclk;
    logic                  r_mosi;
    logic                  r_cs_n;
    logic                  r_req_ready;
    logic                  r_busy;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [DATA_W-1:0]     r_rsp_rdata;
    logic [1:0]            r_sync;
    logic [1:0]            r_samp;
    logic                  r_write;
    logic [6:0]            r_addr;
`ifdef PWM_SPI_HOST_VERIFY_EN
    logic                  r_verify;
    logic [DATA_W-1:0]     r_wdata;
`endif

    logic w_half_end;
    logic w_rise;
    logic w_need_rb;
    logic w_rd_done;
    logic w_err;

    assign w_half_end = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign w_rise     = (r_state == S_SHIFT) && w_half_end && !r_sclk;

    // Readback frame follows a write; the completion then reports the readback.
`ifdef PWM_SPI_HOST_VERIFY_EN
    assign w_need_rb = r_write && !r_verify;
    assign w_rd_done = !r_write || r_verify;
    assign w_err     = r_verify && (r_rx != r_wdata);
`else
    assign w_need_rb = 1'b0;
    assign w_rd_done = !r_write;
    assign w_err     = 1'b0;
`endif

    assign spi_sclk      = r_sclk;
    assign spi_mosi      = r_mosi;
    assign spi_cs_n      = r_cs_n;
    assign bus.req_ready = r_req_ready;
    assign bus.busy      = r_busy;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    // MISO sync; the sample for a rising SCLK edge is taken two clocks later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_samp <= '0;
            r_rx   <= '0;
        end else begin
            r_sync <= {r_sync[0], spi_miso};
            r_samp <= {r_samp[0], w_rise && (r_bit >= BIT_W'(8))};
            if (r_samp[1]) begin
                r_rx <= {r_rx[DATA_W-2:0], r_sync[1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_tx        <= '0;
            r_sclk      <= 1'b0;
            r_mosi      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
`ifdef PWM_SPI_HOST_VERIFY_EN
            r_verify    <= 1'b0;
            r_wdata     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_write     <= bus.req_write;
                        r_addr      <= bus.req_addr;
                        r_tx        <= {bus.req_write, bus.req_addr,
                                        bus.req_write ? bus.req_wdata : DATA_W'(0)};
                        r_mosi      <= bus.req_write;
                        r_cs_n      <= 1'b0;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_SETUP;
`ifdef PWM_SPI_HOST_VERIFY_EN
                        r_verify    <= 1'b0;
                        r_wdata     <= bus.req_wdata;
`endif
                    end
                end
                S_SETUP: begin
                    if (r_cnt == CNT_W'(CS_SETUP - 1)) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (w_half_end) begin
                        r_cnt  <= '0;
                        r_sclk <= ~r_sclk;
                        // Falling edge: advance MOSI and count the bit.
                        if (r_sclk) begin
                            r_bit  <= r_bit + BIT_W'(1);
                            r_tx   <= r_tx << 1;
                            r_mosi <= r_tx[FRAME_BITS-2];
                            if (r_bit == BIT_W'(FRAME_BITS - 1)) begin
                                r_state <= S_HOLD;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (r_cnt == CNT_W'(CS_SETUP - 1)) begin
                        r_cnt   <= '0;
                        r_cs_n  <= 1'b1;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
                        r_cnt <= '0;
                        if (w_need_rb) begin
                            r_tx    <= {1'b0, r_addr, DATA_W'(0)};
                            r_mosi  <= 1'b0;
                            r_cs_n  <= 1'b0;
                            r_state <= S_SETUP;
`ifdef PWM_SPI_HOST_VERIFY_EN
                            r_verify <= 1'b1;
`endif
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= w_err;
                            if (w_rd_done) begin
                                r_rsp_rdata <= r_rx;
                            end
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_spi_host.sv
// Directed bench for pwm_spi_host with a cycle-sampled SPI mode-0 slave model.
// Expectations adapt when PWM_SPI_HOST_VERIFY_EN is defined.
module tb_pwm_spi_host;
    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned CS_SETUP   = 2;
    localparam int unsigned DATA_BYTES = 4;
`ifdef PWM_SPI_HOST_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    // Accept cycle through rsp_valid cycle, inclusive: 1+2+320+2+4+1.
    localparam int LAT_ONE = 330;
    // A verified write runs two frames of 328 cycles each before DONE.
    localparam int LAT_WR  = VERIFY ? 658 : 330;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pwm_spi_host_if #(.DATA_BYTES(DATA_BYTES)) bus ();
    logic spi_sclk, spi_mosi, spi_cs_n;
    logic spi_miso = 1'b0;

    pwm_spi_host #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .DATA_BYTES(DATA_BYTES)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model and bus monitors, evaluated mid-cycle.
    logic [31:0] slv_reply = 32'h0;
    logic [39:0] slv_sh = '0;
    logic [39:0] slv_tx = '0;
    int slv_bits = 0, rises_total = 0, rsp_count = 0, ready_viol = 0, cs_high_run = 0;
    logic cs_prev = 1'b1, sclk_prev = 1'b0, had_frame = 1'b0;
    logic [39:0] fq[$];
    int gq[$];

    always @(negedge clk) begin
        if (spi_sclk && !sclk_prev) rises_total++;
        if (bus.rsp_valid) rsp_count++;
        if (!spi_cs_n && bus.req_ready) ready_viol++;
        if (bus.rsp_valid && bus.req_ready) ready_viol++;
        if (!spi_cs_n && cs_prev) begin
            if (had_frame) gq.push_back(cs_high_run);
            slv_bits = 0;
            slv_sh   = '0;
            slv_tx   = {8'h00, slv_reply};
            spi_miso = slv_tx[39];
        end else if (!spi_cs_n) begin
            if (spi_sclk && !sclk_prev) begin
                slv_sh = {slv_sh[38:0], spi_mosi};
                slv_bits++;
            end
            if (!spi_sclk && sclk_prev) begin
                slv_tx   = slv_tx << 1;
                spi_miso = slv_tx[39];
            end
        end
        if (spi_cs_n && !cs_prev) begin
            fq.push_back(slv_sh);
            had_frame   = 1'b1;
            cs_high_run = 0;
        end
        if (spi_cs_n) cs_high_run++;
        cs_prev   = spi_cs_n;
        sclk_prev = spi_sclk;
    end

    // Offer a request at the current negedge; returns one negedge after acceptance.
    task automatic send(input logic wr, input logic [6:0] addr, input logic [31:0] wd,
                        input bit keep_valid, output int acc_cyc, output bit ok);
        int g = 0;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        ok      = (g < 2000);
        acc_cyc = cyc;
        @(negedge clk);
        if (!keep_valid) bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok, output logic [31:0] rd, output logic err,
                            output int rcyc);
        int g = 0;
        while (!bus.rsp_valid && g < 3000) begin
            @(negedge clk);
            g++;
        end
        ok   = bus.rsp_valid;
        rd   = bus.rsp_rdata;
        err  = bus.rsp_err;
        rcyc = cyc;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int r0;
        #1 rst_n = 1'b0;
        repeat (4) @(negedge clk);
        n_chk++; if (spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b want 1", spi_cs_n); end
        n_chk++; if (spi_sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", spi_sclk); end
        n_chk++; if (spi_mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
        n_chk++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_chk++; if (bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rsp_rdata); end
        n_chk++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.rsp_err); end
        rst_n = 1'b1;
        r0 = rises_total;
        repeat (100) @(negedge clk);
        n_chk++; if (rises_total - r0 !== 0) begin n_fail++; $display("FAIL idle_sclk_edges: got %0d want 0", rises_total - r0); end
        n_chk++; if (fq.size() !== 0) begin n_fail++; $display("FAIL idle_frames: got %0d want 0", fq.size()); end
    endtask

    task automatic test_write();
        int base, r0, acc, rc;
        bit ok;
        logic [31:0] rd;
        logic err;
        slv_reply = 32'h1234_5678;
        base = fq.size();
        r0 = rises_total;
        send(1'b1, 7'd2, 32'h1234_5678, 1'b0, acc, ok);
        wait_rsp(ok, rd, err, rc);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL write_rsp_timeout: got none want rsp_valid"); end
        n_chk++; if (fq.size() - base !== (VERIFY ? 2 : 1)) begin n_fail++; $display("FAIL write_frames: got %0d want %0d", fq.size() - base, VERIFY ? 2 : 1); end
        n_chk++; if (fq[base] !== 40'h82_1234_5678) begin n_fail++; $display("FAIL write_frame: got %h want 8212345678", fq[base]); end
        n_chk++; if (rises_total - r0 !== (VERIFY ? 80 : 40)) begin n_fail++; $display("FAIL write_sclk_edges: got %0d want %0d", rises_total - r0, VERIFY ? 80 : 40); end
        n_chk++; if (rc - acc + 1 !== LAT_WR) begin n_fail++; $display("FAIL write_latency: got %0d want %0d", rc - acc + 1, LAT_WR); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL write_err: got %b want 0", err); end
        n_chk++; if (rd !== (VERIFY ? 32'h1234_5678 : 32'h0)) begin n_fail++; $display("FAIL write_rdata: got %h want %h", rd, VERIFY ? 32'h1234_5678 : 32'h0); end
        n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL write_pulse_width: got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_read();
        int base, r0, acc, rc;
        bit ok;
        logic [31:0] rd;
        logic err;
        slv_reply = 32'hDEAD_BEEF;
        base = fq.size();
        r0 = rises_total;
        send(1'b0, 7'd1, 32'hA5A5_A5A5, 1'b0, acc, ok);
        wait_rsp(ok, rd, err, rc);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL read_rsp_timeout: got none want rsp_valid"); end
        n_chk++; if (fq[base] !== 40'h01_0000_0000) begin n_fail++; $display("FAIL read_frame: got %h want 0100000000", fq[base]); end
        n_chk++; if (rises_total - r0 !== 40) begin n_fail++; $display("FAIL read_sclk_edges: got %0d want 40", rises_total - r0); end
        n_chk++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_rdata: got %h want deadbeef", rd); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL read_err: got %b want 0", err); end
        n_chk++; if (rc - acc + 1 !== LAT_ONE) begin n_fail++; $display("FAIL read_latency: got %0d want %0d", rc - acc + 1, LAT_ONE); end
        n_chk++; if (bus.rsp_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_rdata_hold: got %h want deadbeef", bus.rsp_rdata); end
    endtask

    task automatic test_back_to_back();
        int base, gbase, v0, p0, acc1, acc2, rc, mg;
        bit ok1, ok2, ok;
        logic [31:0] rd;
        logic err;
        slv_reply = 32'h0000_0007;
        base  = fq.size();
        gbase = gq.size();
        v0    = ready_viol;
        p0    = rsp_count;
        send(1'b1, 7'd5, 32'h0000_0001, 1'b1, acc1, ok1);
        send(1'b0, 7'd0, 32'hFFFF_FFFF, 1'b0, acc2, ok2);
        n_chk++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL b2b_accept_timeout: got %b%b want 11", ok1, ok2); end
        n_chk++; if (rsp_count - p0 !== 1) begin n_fail++; $display("FAIL b2b_first_done: got %0d want 1", rsp_count - p0); end
        wait_rsp(ok, rd, err, rc);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL b2b_rsp_timeout: got none want rsp_valid"); end
        n_chk++; if (fq.size() - base !== (VERIFY ? 3 : 2)) begin n_fail++; $display("FAIL b2b_frames: got %0d want %0d", fq.size() - base, VERIFY ? 3 : 2); end
        n_chk++; if (fq[base] !== 40'h85_0000_0001) begin n_fail++; $display("FAIL b2b_frame0: got %h want 8500000001", fq[base]); end
        n_chk++; if (fq[base + (VERIFY ? 2 : 1)] !== 40'h00_0000_0000) begin n_fail++; $display("FAIL b2b_frame1: got %h want 0000000000", fq[base + (VERIFY ? 2 : 1)]); end
        n_chk++; if (rd !== 32'h0000_0007) begin n_fail++; $display("FAIL b2b_rdata: got %h want 00000007", rd); end
        mg = 1000;
        for (int i = gbase; i < gq.size(); i++) if (gq[i] < mg) mg = gq[i];
        n_chk++; if (mg < CLK_DIV) begin n_fail++; $display("FAIL b2b_cs_gap: got %0d want >= %0d", mg, CLK_DIV); end
        n_chk++; if (ready_viol - v0 !== 0) begin n_fail++; $display("FAIL b2b_ready_in_frame: got %0d want 0", ready_viol - v0); end
    endtask

    task automatic test_abort();
        int p0, acc, rc, g, base;
        bit ok;
        logic [31:0] rd;
        logic err;
        slv_reply = 32'h0BAD_F00D;
        p0 = rsp_count;
        send(1'b1, 7'd4, 32'hCAFE_F00D, 1'b0, acc, ok);
        g = 0;
        while (slv_bits < 17 && g < 1000) begin
            @(negedge clk);
            #1;
            g++;
        end
        n_chk++; if (g >= 1000) begin n_fail++; $display("FAIL abort_bit17_timeout: got %0d bits want 17", slv_bits); end
        n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_mid: got %b want 1", bus.busy); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL abort_cs_async: got %b want 1", spi_cs_n); end
        n_chk++; if (spi_sclk !== 1'b0) begin n_fail++; $display("FAIL abort_sclk: got %b want 0", spi_sclk); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_chk++; if (rsp_count - p0 !== 0) begin n_fail++; $display("FAIL abort_no_rsp: got %0d want 0", rsp_count - p0); end
        base = fq.size();
        send(1'b0, 7'd2, 32'h0, 1'b0, acc, ok);
        wait_rsp(ok, rd, err, rc);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL abort_next_timeout: got none want rsp_valid"); end
        n_chk++; if (fq[base] !== 40'h02_0000_0000) begin n_fail++; $display("FAIL abort_next_frame: got %h want 0200000000", fq[base]); end
        n_chk++; if (rd !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL abort_next_rdata: got %h want 0badf00d", rd); end
        n_chk++; if (rc - acc + 1 !== LAT_ONE) begin n_fail++; $display("FAIL abort_next_latency: got %0d want %0d", rc - acc + 1, LAT_ONE); end
    endtask

`ifdef PWM_SPI_HOST_VERIFY_EN
    task automatic test_verify();
        int base, acc, rc;
        bit ok;
        logic [31:0] rd;
        logic err;
        slv_reply = 32'h0000_00FE;
        base = fq.size();
        send(1'b1, 7'd3, 32'h0000_00FF, 1'b0, acc, ok);
        wait_rsp(ok, rd, err, rc);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL verify_timeout: got none want rsp_valid"); end
        n_chk++; if (fq.size() - base !== 2) begin n_fail++; $display("FAIL verify_frames: got %0d want 2", fq.size() - base); end
        n_chk++; if (fq[base] !== 40'h83_0000_00FF) begin n_fail++; $display("FAIL verify_frame0: got %h want 83000000ff", fq[base]); end
        n_chk++; if (fq[base + 1] !== 40'h03_0000_0000) begin n_fail++; $display("FAIL verify_frame1: got %h want 0300000000", fq[base + 1]); end
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL verify_err: got %b want 1", err); end
        n_chk++; if (rd !== 32'h0000_00FE) begin n_fail++; $display("FAIL verify_rdata: got %h want 000000fe", rd); end
    endtask
`endif

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_abort();
`ifdef PWM_SPI_HOST_VERIFY_EN
        test_verify();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pwm_spi_host.md
Name: pwm_spi_host

Overview:
SPI mode-0 master (initiator) that drives the PWM register file over its 4-wire SPI slave interface from an on-chip request port. It is used in the lab/FPGA harness and in any on-chip controller that reconfigures the PWM block. Each request is one framed transaction with chip-select low: a command byte, then DATA_BYTES data bytes. The block returns read data and a completion pulse.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period; legal values are 2 or more.
CS_SETUP, 2, clk cycles from cs_n falling to the first SCLK rising edge, and from the last SCLK falling edge to cs_n rising.
DATA_BYTES, 4, data bytes per transaction; PWM registers are 32-bit.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request offered
req_ready  out  1  request accepted when high together with req_valid
req_write  in  1  1 = write, 0 = read
req_addr  in  7  register address: 0 counter_value, 1 prescaler, 2-4 duty_cycle_1..3, 5 enable_pwm
req_wdata  in  8*DATA_BYTES  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  8*DATA_BYTES  read data; valid while rsp_valid is high and held until the next read completes
rsp_err  out  1  verify mismatch; qualified by rsp_valid
busy  out  1  transaction in progress
spi_sclk  out  1  SPI clock; idles low
spi_mosi  out  1  master out
spi_miso  in  1  master in; synchronized with a 2-flop synchronizer
spi_cs_n  out  1  chip select, active low

Behaviour:
- Clock and reset: a single clock domain. Reset is asynchronous and active-low on rst_n.
- Reset values: spi_cs_n=1, spi_sclk=0, spi_mosi=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
- Reset mid-transaction: cs_n rises immediately, the frame is aborted, and no rsp_valid is issued.
- Frame format:
  - Command byte = {req_write, req_addr}, sent MSB first.
  - It is followed by DATA_BYTES bytes. Write: req_wdata, MSB first. Read: 0x00 is driven on MOSI.
  - Total frame length is 8*(1+DATA_BYTES) bits, which is 40 by default.
- SPI mode 0:
  - MOSI is valid before each rising SCLK edge. The first bit is driven on entry to CS_SETUP.
  - MOSI changes only after a falling SCLK edge.
  - MISO is sampled at the rising edge. Because of the 2-flop sync, the sample is taken from the synchronized value 2 clk later, which requires CLK_DIV >= 3 for exact alignment.
  - MISO bits from the command byte are discarded. Data-phase bits are shifted into rsp_rdata, MSB first.
- FSM:
  - IDLE: req_ready=1. req_valid&&req_ready latches the request, drops cs_n, and moves to CS_SETUP.
  - CS_SETUP: wait CS_SETUP cycles, then SHIFT.
  - SHIFT: SCLK toggles every CLK_DIV cycles. A bit counter counts the falling edges. After the last falling edge, go to CS_HOLD.
  - CS_HOLD: wait CS_SETUP cycles, raise cs_n, go to GAP.
  - GAP: cs_n stays high for CLK_DIV cycles, then DONE.
  - DONE: rsp_valid=1 for one cycle, then IDLE.
- Handshake:
  - req_ready is low in every state except IDLE; busy is its complement.
  - A request asserted in the same cycle as rsp_valid is accepted only on the following cycle, in IDLE.
- Latency from acceptance to rsp_valid = 1 + CS_SETUP + 2*CLK_DIV*8*(1+DATA_BYTES) + CS_SETUP + CLK_DIV + 1 cycles. With the defaults that is 330.
- Addresses 6 to 127 are sent unchanged; the slave ignores them, so read data is whatever appears on MISO.
- rsp_rdata is updated only on read completions; writes leave it unchanged.

Optional Feature:
Macro: PWM_SPI_HOST_VERIFY_EN.
- With the macro defined, every write is automatically followed by a read frame to the same address, after the GAP state.
- The completion pulse rsp_valid fires only after that readback frame, with rsp_rdata set to the readback value and rsp_err = (readback != written data).
- Reads are unaffected and return rsp_err=0.
- With the macro undefined, rsp_err is tied to 0 and writes complete after one frame.

Test Plan:
- Reset: hold rst_n low, then release. Required: cs_n=1, sclk=0, req_ready=1, and no SCLK edges for 100 cycles.
- Write: write addr=2, data=0x1234_5678. Required:
  - the slave model captures command byte 0x82 and data 0x12, 0x34, 0x56, 0x78;
  - exactly 40 rising SCLK edges occur;
  - rsp_valid pulses 330 cycles after acceptance.
- Read: read addr=1 with the slave model returning 0xDEAD_BEEF. Required:
  - the command byte is 0x01 and MOSI data is all zero;
  - rsp_rdata=0xDEADBEEF when rsp_valid pulses.
- Back-to-back: req_valid is held high for write addr=5 data=1, then read addr=0. Required:
  - cs_n is high for at least CLK_DIV cycles between frames;
  - req_ready stays low throughout each frame;
  - both frames arrive in order.
- Abort: assert rst_n low at bit 17 of a frame. Required: cs_n rises asynchronously, no rsp_valid, and the next request completes normally.
- Verify (PWM_SPI_HOST_VERIFY_EN): write 0x0000_00FF to addr 3 with the slave returning 0x0000_00FE. Required:
  - two frames, 0x83 then 0x03;
  - rsp_err=1 and rsp_rdata=0xFE on rsp_valid.
